// File: rtl/sync_reqack_edge_core.sv
// Single-clock model of register-CDC transport: a toggle-based edge propagator
// and a req/ack handshake carried as two-phase toggles through sync chains.
module sync_reqack_edge_core #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic edge_i,
  output logic edge_o,
  input  logic src_req_i,
  output logic src_ack_o,
  output logic dst_req_o,
  input  logic dst_ack_i,
  output logic busy_o
);

  logic                  r_tx_tog;
  logic [SyncStages-1:0] r_edge_sync;
  logic                  r_edge_last_q;

  logic                  r_req_tog;
  logic                  r_pending;
  logic [SyncStages-1:0] r_req_sync;

  logic                  r_ack_tog;
  logic [SyncStages-1:0] r_ack_sync;

  logic w_edge_last;
  logic w_req_s;
  logic w_ack_s;
  logic w_start;
  logic w_src_ack;
  logic w_dst_req;
  logic w_dst_take;

  assign w_edge_last = r_edge_sync[SyncStages-1];
  assign w_req_s     = r_req_sync[SyncStages-1];
  assign w_ack_s     = r_ack_sync[SyncStages-1];

  // The handshake is done once the returned ack toggle matches the sent request toggle.
  assign w_src_ack  = r_pending & (w_ack_s == r_req_tog);
  assign w_start    = src_req_i & ~r_pending;
  assign w_dst_req  = w_req_s ^ r_ack_tog;
  assign w_dst_take = w_dst_req & dst_ack_i;

  assign edge_o    = w_edge_last ^ r_edge_last_q;
  assign src_ack_o = w_src_ack;
  assign dst_req_o = w_dst_req;
  assign busy_o    = r_pending;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_tog      <= 1'b0;
      r_edge_sync   <= '0;
      r_edge_last_q <= 1'b0;
      r_req_tog     <= 1'b0;
      r_pending     <= 1'b0;
      r_req_sync    <= '0;
      r_ack_tog     <= 1'b0;
      r_ack_sync    <= '0;
    end else begin
      r_tx_tog       <= r_tx_tog ^ edge_i;
      r_edge_sync[0] <= r_tx_tog;
      r_req_sync[0]  <= r_req_tog;
      r_ack_sync[0]  <= r_ack_tog;
      for (int i = 1; i < SyncStages; i++) begin
        r_edge_sync[i] <= r_edge_sync[i-1];
        r_req_sync[i]  <= r_req_sync[i-1];
        r_ack_sync[i]  <= r_ack_sync[i-1];
      end
      r_edge_last_q <= w_edge_last;

      if (w_start) begin
        r_req_tog <= ~r_req_tog;
      end
      // Completion wins; a request seen during the ack cycle waits one cycle.
      if (w_src_ack) begin
        r_pending <= 1'b0;
      end else if (w_start) begin
        r_pending <= 1'b1;
      end

      if (w_dst_take) begin
        r_ack_tog <= ~r_ack_tog;
      end
    end
  end

endmodule

// File: tb/tb_sync_reqack_edge_core.sv
// Bench for sync_reqack_edge_core: directed latency scenarios plus randomized
// traffic checked against a latency-rule reference model.
module tb_sync_reqack_edge_core;

  localparam int S = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic edge_i = 1'b0;
  logic src_req_i = 1'b0;
  logic ack_drv = 1'b0;
  logic ack_tie = 1'b0;
  logic edge_o;
  logic src_ack_o;
  logic dst_req_o;
  logic dst_ack_i;
  logic busy_o;

  assign dst_ack_i = ack_tie ? dst_req_o : ack_drv;

  sync_reqack_edge_core #(.SyncStages(S)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .edge_i    (edge_i),
    .edge_o    (edge_o),
    .src_req_i (src_req_i),
    .src_ack_o (src_ack_o),
    .dst_req_o (dst_req_o),
    .dst_ack_i (dst_ack_i),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur = 0;

  // Reference model: events scheduled by latency rules, indexed by cycle.
  bit sched_edge[0:2047];
  bit m_pending;
  bit m_acked;
  int m_rise;
  int m_ack_at;
  bit exp_edge, exp_src_ack, exp_dst_req, exp_busy;

  task automatic model_reset();
    m_pending = 1'b0;
    m_acked   = 1'b1;
    m_rise    = -1;
    m_ack_at  = -1;
    for (int i = 0; i < 2048; i++) sched_edge[i] = 1'b0;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    edge_i = 1'b0;
    src_req_i = 1'b0;
    ack_drv = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  // Drives one cycle's inputs, computes the expected outputs for it, and
  // returns at the negedge so the caller can compare.
  task automatic drive_cycle(input bit e, input bit r, input bit a);
    bit ack_seen;
    @(posedge clk_i);
    #1;
    edge_i = e;
    src_req_i = r;
    ack_drv = a;
    cur = cyc;
    exp_edge    = sched_edge[cyc];
    exp_dst_req = (m_rise >= 0) && (cyc >= m_rise) && !m_acked;
    exp_src_ack = (cyc == m_ack_at);
    exp_busy    = m_pending;
    @(negedge clk_i);
    if (e) sched_edge[cyc + S + 1] = 1'b1;
    ack_seen = ack_tie ? exp_dst_req : a;
    if (exp_dst_req && ack_seen) begin
      m_acked  = 1'b1;
      m_ack_at = cyc + S + 1;
    end
    if (exp_src_ack) begin
      m_pending = 1'b0;
    end else if (!m_pending && r) begin
      m_pending = 1'b1;
      m_rise    = cyc + 1 + S;
      m_acked   = 1'b0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    logic [3:0] outs;
    ack_tie = 1'b0;
    rst_i = 1'b1;
    edge_i = 1'b0;
    src_req_i = 1'b0;
    ack_drv = 1'b0;
    repeat (2) @(negedge clk_i);
    outs = {edge_o, src_ack_o, dst_req_o, busy_o};
    checks++;
    if (outs !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold got %b exp 0000", outs);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    cyc = 0;
    drive_cycle(0, 0, 0);
    outs = {edge_o, src_ack_o, dst_req_o, busy_o};
    checks++;
    if (outs !== 4'b0) begin
      errors++;
      $display("FAIL reset_first_cycle got %b exp 0000", outs);
    end
    for (int c = 1; c <= 5; c++) begin
      drive_cycle(1, 1, 0);
      checks++;
      if (dst_req_o !== (cur >= 4)) begin
        errors++;
        $display("FAIL reset_pre_dst_req cycle %0d got %b exp %b", cur, dst_req_o, (cur >= 4));
      end
    end
    #2 rst_i = 1'b1;
    #1;
    outs = {edge_o, src_ack_o, dst_req_o, busy_o};
    checks++;
    if (outs !== 4'b0) begin
      errors++;
      $display("FAIL reset_async got %b exp 0000", outs);
    end
    edge_i = 1'b0;
    src_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(0, 0, 0);
      outs = {edge_o, src_ack_o, dst_req_o, busy_o};
      checks++;
      if (outs !== 4'b0) begin
        errors++;
        $display("FAIL reset_aborted cycle %0d got %b exp 0000", cur, outs);
      end
    end
    ack_tie = 1'b1;
    for (int c = 20; c <= 28; c++) begin
      drive_cycle(0, (c <= 26), 0);
      checks++;
      if (src_ack_o !== (c == 26)) begin
        errors++;
        $display("FAIL reset_next_req cycle %0d got %b exp %b", c, src_ack_o, (c == 26));
      end
    end
  endtask

  task automatic test_edge();
    bit exp;
    reset_dut();
    for (int c = 0; c <= 30; c++) begin
      drive_cycle((c == 10) || (c >= 20 && c <= 22), 0, 0);
      exp = (c == 13) || (c >= 23 && c <= 25);
      checks++;
      if (edge_o !== exp) begin
        errors++;
        $display("FAIL edge cycle %0d got %b exp %b", c, edge_o, exp);
      end
    end
  endtask

  task automatic test_immediate_ack();
    ack_tie = 1'b1;
    reset_dut();
    for (int c = 0; c <= 30; c++) begin
      drive_cycle(0, (c >= 10 && c <= 16), 0);
      checks++;
      if ({dst_req_o, src_ack_o, busy_o} !== {(c == 13), (c == 16), (c >= 11 && c <= 16)}) begin
        errors++;
        $display("FAIL immediate cycle %0d got req/ack/busy %b%b%b exp %b%b%b", c,
                 dst_req_o, src_ack_o, busy_o, (c == 13), (c == 16), (c >= 11 && c <= 16));
      end
    end
  endtask

  task automatic test_delayed_ack();
    ack_tie = 1'b0;
    reset_dut();
    for (int c = 0; c <= 30; c++) begin
      drive_cycle(0, (c >= 10 && c <= 23), (c == 20));
      checks++;
      if ({dst_req_o, src_ack_o, busy_o} !== {(c >= 13 && c <= 20), (c == 23), (c >= 11 && c <= 23)}) begin
        errors++;
        $display("FAIL delayed cycle %0d got req/ack/busy %b%b%b exp %b%b%b", c,
                 dst_req_o, src_ack_o, busy_o, (c >= 13 && c <= 20), (c == 23), (c >= 11 && c <= 23));
      end
    end
  endtask

  task automatic test_back_to_back();
    ack_tie = 1'b1;
    reset_dut();
    for (int c = 0; c <= 40; c++) begin
      drive_cycle(0, 1, 0);
      checks++;
      if ({src_ack_o, busy_o} !== {(c >= 6 && (c - 6) % 7 == 0), (c % 7 != 0)}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got ack/busy %b%b exp %b%b", c, src_ack_o, busy_o,
                 (c >= 6 && (c - 6) % 7 == 0), (c % 7 != 0));
      end
    end
  endtask

  task automatic test_violation();
    ack_tie = 1'b1;
    reset_dut();
    for (int c = 0; c <= 25; c++) begin
      drive_cycle(0, (c >= 10 && c <= 11), 0);
      checks++;
      if ({dst_req_o, src_ack_o} !== {(c == 13), (c == 16)}) begin
        errors++;
        $display("FAIL violation cycle %0d got req/ack %b%b exp %b%b", c, dst_req_o, src_ack_o,
                 (c == 13), (c == 16));
      end
    end
  endtask

  task automatic test_random();
    bit r;
    for (int round = 0; round < 4; round++) begin
      ack_tie = round[0];
      reset_dut();
      r = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 7) == 0) r = ~r;
        drive_cycle(($urandom_range(0, 2) == 0), r, ($urandom_range(0, 3) == 0));
        checks++;
        if ({edge_o, src_ack_o, dst_req_o, busy_o} !== {exp_edge, exp_src_ack, exp_dst_req, exp_busy}) begin
          errors++;
          $display("FAIL random round %0d cycle %0d got edge/ack/req/busy %b%b%b%b exp %b%b%b%b",
                   round, cur, edge_o, src_ack_o, dst_req_o, busy_o,
                   exp_edge, exp_src_ack, exp_dst_req, exp_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_immediate_ack();
    test_delayed_ack();
    test_back_to_back();
    test_violation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
